// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: three requester handshakes, hold input, register-file drive.
`timescale 1ns/1ps
interface wb_arbiter_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 5
);
  logic          ld_valid;
  logic          pc_valid;
  logic          alu_valid;
  logic [AW-1:0] ld_addr;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] pc_data;
  logic [DW-1:0] alu_data;
  logic          ld_ready;
  logic          pc_ready;
  logic          alu_ready;
  logic          wb_hold;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_load;
  logic          wb_pc;
  logic          wb_alu;
  logic [15:0]   conflict_cnt;

  // Requester / pipeline-control side
  modport master (
    output ld_valid, pc_valid, alu_valid,
    output ld_addr, pc_addr, alu_addr,
    output ld_data, pc_data, alu_data,
    output wb_hold,
    input  ld_ready, pc_ready, alu_ready,
    input  wb_en, wb_addr, wb_data, wb_load, wb_pc, wb_alu, conflict_cnt
  );

  // Arbiter side
  modport slave (
    input  ld_valid, pc_valid, alu_valid,
    input  ld_addr, pc_addr, alu_addr,
    input  ld_data, pc_data, alu_data,
    input  wb_hold,
    output ld_ready, pc_ready, alu_ready,
    output wb_en, wb_addr, wb_data, wb_load, wb_pc, wb_alu, conflict_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: load / PC+4 / ALU into one register-file write port.
`timescale 1ns/1ps
module wb_arbiter #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 5
) (
  input logic        clk,
  input logic        rstn,
  wb_arbiter_if.slave bus
);

  localparam int unsigned NREQ = 3;
  localparam int unsigned CW   = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Requester indices; ptr holds the first index searched next cycle
  localparam logic [1:0] IDX_LD  = 2'd0;
  localparam logic [1:0] IDX_PC  = 2'd1;
  localparam logic [1:0] IDX_ALU = 2'd2;

  logic [1:0]      ptr_q,     ptr_d;
  logic            wb_en_q,   wb_en_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic [NREQ-1:0] wb_sel_q,  wb_sel_d;   // {alu, pc, load}
  logic [CW-1:0]   cnt_q,     cnt_d;

  logic [NREQ-1:0] req_c;
  logic [NREQ-1:0] gnt_c;
  logic [1:0]      gnt_idx_c;
  logic            hs_c;
  logic [2:0]      idx_c;
  logic            multi_c;
  logic [AW-1:0]   sel_addr_c;
  logic [DW-1:0]   sel_data_c;

  assign req_c   = {bus.alu_valid, bus.pc_valid, bus.ld_valid};
  assign multi_c = (req_c[0] & req_c[1]) | (req_c[0] & req_c[2]) | (req_c[1] & req_c[2]);

  // Round-robin search starting at ptr; no grant in reset or while held
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = IDX_LD;
    hs_c      = 1'b0;
    idx_c     = '0;
    if (rstn && !bus.wb_hold) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        idx_c = 3'(ptr_q) + 3'(k);
        if (idx_c >= 3'(NREQ)) idx_c = idx_c - 3'(NREQ);
        if (!hs_c && req_c[idx_c[1:0]]) begin
          gnt_c[idx_c[1:0]] = 1'b1;
          gnt_idx_c         = idx_c[1:0];
          hs_c              = 1'b1;
        end
      end
    end
  end

  // Payload of the granted requester
  always_comb begin
    sel_addr_c = bus.ld_addr;
    sel_data_c = bus.ld_data;
    case (gnt_idx_c)
      IDX_PC: begin
        sel_addr_c = bus.pc_addr;
        sel_data_c = bus.pc_data;
      end
      IDX_ALU: begin
        sel_addr_c = bus.alu_addr;
        sel_data_c = bus.alu_data;
      end
      default: begin
        sel_addr_c = bus.ld_addr;
        sel_data_c = bus.ld_data;
      end
    endcase
  end

  // Next-state: pointer advance, output stage load/idle/hold, contention counter
  always_comb begin
    ptr_d     = ptr_q;
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_sel_d  = wb_sel_q;
    cnt_d     = cnt_q;
    if (!bus.wb_hold) begin
      if (hs_c) begin
        ptr_d     = (gnt_idx_c == IDX_ALU) ? IDX_LD : gnt_idx_c + 2'd1;
        wb_addr_d = sel_addr_c;
        wb_data_d = sel_data_c;
        // Writes to x0 complete the handshake but never reach the register file
        wb_en_d   = |sel_addr_c;
        wb_sel_d  = (|sel_addr_c) ? gnt_c : '0;
      end else begin
        wb_en_d  = 1'b0;
        wb_sel_d = '0;
      end
      if (multi_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q     <= IDX_LD;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_sel_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_sel_q  <= wb_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ld_ready     = gnt_c[IDX_LD];
  assign bus.pc_ready     = gnt_c[IDX_PC];
  assign bus.alu_ready    = gnt_c[IDX_ALU];
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_load      = wb_sel_q[IDX_LD];
  assign bus.wb_pc        = wb_sel_q[IDX_PC];
  assign bus.wb_alu       = wb_sel_q[IDX_ALU];
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, corner sequences, randomized model check.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  valid;     // {alu, pc, ld}
    logic        hold;
    logic [2:0]  exp_rdy;   // {alu, pc, ld}
    logic        exp_en;
    logic [2:0]  exp_sel;   // {alu, pc, ld}
    logic [4:0]  exp_addr;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ld_valid  = 1'b0; bus.pc_valid  = 1'b0; bus.alu_valid = 1'b0;
    bus.ld_addr   = '0;   bus.pc_addr   = '0;   bus.alu_addr  = '0;
    bus.ld_data   = '0;   bus.pc_data   = '0;   bus.alu_data  = '0;
    bus.wb_hold   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [2:0] rdy_vec();
    return {bus.alu_ready, bus.pc_ready, bus.ld_ready};
  endfunction

  function automatic logic [2:0] sel_vec();
    return {bus.wb_alu, bus.wb_pc, bus.wb_load};
  endfunction

  // ---------------- reference model state (random phase) ----------------
  int          m_ptr;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  logic [2:0]  m_sel;
  int          m_cnt;
  logic        rv [3];
  logic [4:0]  ra [3];
  logic [63:0] rd [3];

  task automatic drive_reqs();
    bus.ld_valid  = rv[0]; bus.ld_addr  = ra[0]; bus.ld_data  = rd[0];
    bus.pc_valid  = rv[1]; bus.pc_addr  = ra[1]; bus.pc_data  = rd[1];
    bus.alu_valid = rv[2]; bus.alu_addr = ra[2]; bus.alu_data = rd[2];
  endtask

  initial begin
    int g;
    int nv;
    logic [2:0] exp_rdy;

    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    clear_inputs();

    // ld -> addr 1 / 0x11, pc -> addr 2 / 0x22, alu -> addr 3 / 0x33
    tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b1, 3'b001, 5'd1, 16'd1};
    tbl[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 3'b010, 5'd2, 16'd2};
    tbl[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 3'b100, 5'd3, 16'd3};
    tbl[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 3'b001, 5'd1, 16'd4};
    tbl[4]  = '{3'b101, 1'b0, 3'b100, 1'b1, 3'b100, 5'd3, 16'd5};
    tbl[5]  = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 5'd3, 16'd5};
    tbl[6]  = '{3'b010, 1'b0, 3'b010, 1'b1, 3'b010, 5'd2, 16'd5};
    tbl[7]  = '{3'b011, 1'b1, 3'b000, 1'b1, 3'b010, 5'd2, 16'd5};
    tbl[8]  = '{3'b011, 1'b0, 3'b001, 1'b1, 3'b001, 5'd1, 16'd6};
    tbl[9]  = '{3'b100, 1'b0, 3'b100, 1'b1, 3'b100, 5'd3, 16'd6};
    tbl[10] = '{3'b000, 1'b1, 3'b000, 1'b1, 3'b100, 5'd3, 16'd6};
    tbl[11] = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 5'd3, 16'd6};

    // ---------------- reset state ----------------
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.pc_valid = 1'b1; bus.alu_valid = 1'b1;
    #1;
    chk("reset_ready", 64'(rdy_vec()), 64'd0);
    chk("reset_en", 64'(bus.wb_en), 64'd0);
    chk("reset_addr", 64'(bus.wb_addr), 64'd0);
    chk("reset_data", bus.wb_data, 64'd0);
    chk("reset_sel", 64'(sel_vec()), 64'd0);
    chk("reset_cnt", 64'(bus.conflict_cnt), 64'd0);

    // ---------------- vector table ----------------
    do_reset();
    bus.ld_addr = 5'd1;  bus.ld_data  = 64'h11;
    bus.pc_addr = 5'd2;  bus.pc_data  = 64'h22;
    bus.alu_addr = 5'd3; bus.alu_data = 64'h33;
    for (int i = 0; i < 12; i++) begin
      bus.ld_valid  = tbl[i].valid[0];
      bus.pc_valid  = tbl[i].valid[1];
      bus.alu_valid = tbl[i].valid[2];
      bus.wb_hold   = tbl[i].hold;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(rdy_vec()), 64'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_en", i), 64'(bus.wb_en), 64'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_sel", i), 64'(sel_vec()), 64'(tbl[i].exp_sel));
      chk($sformatf("tbl%0d_addr", i), 64'(bus.wb_addr), 64'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_data", i), bus.wb_data, 64'(tbl[i].exp_addr) * 64'h11);
      chk($sformatf("tbl%0d_cnt", i), 64'(bus.conflict_cnt), 64'(tbl[i].exp_cnt));
    end

    // ---------------- single ALU request ----------------
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 64'h1234;
    #1;
    chk("single_ready", 64'(rdy_vec()), 64'b100);
    tick();
    bus.alu_valid = 1'b0;
    chk("single_en", 64'(bus.wb_en), 64'd1);
    chk("single_addr", 64'(bus.wb_addr), 64'd5);
    chk("single_data", bus.wb_data, 64'h1234);
    chk("single_sel", 64'(sel_vec()), 64'b100);

    // ---------------- x0 write discarded ----------------
    do_reset();
    bus.pc_valid = 1'b1; bus.pc_addr = 5'd0; bus.pc_data = 64'hABCD;
    #1;
    chk("x0_ready", 64'(rdy_vec()), 64'b010);
    tick();
    bus.pc_valid = 1'b0;
    chk("x0_en", 64'(bus.wb_en), 64'd0);
    chk("x0_sel", 64'(sel_vec()), 64'd0);

    // ---------------- hold freezes everything ----------------
    do_reset();
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd3; bus.ld_data = 64'h33;
    #1;
    chk("hold_ld_ready", 64'(rdy_vec()), 64'b001);
    tick();
    bus.ld_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 64'h77;
    bus.wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d_ready", i), 64'(rdy_vec()), 64'd0);
      tick();
      chk($sformatf("hold%0d_en", i), 64'(bus.wb_en), 64'd1);
      chk($sformatf("hold%0d_addr", i), 64'(bus.wb_addr), 64'd3);
      chk($sformatf("hold%0d_sel", i), 64'(sel_vec()), 64'b001);
      chk($sformatf("hold%0d_cnt", i), 64'(bus.conflict_cnt), 64'd0);
    end
    bus.wb_hold = 1'b0;
    #1;
    chk("release_ready", 64'(rdy_vec()), 64'b100);
    tick();
    bus.alu_valid = 1'b0;
    chk("release_sel", 64'(sel_vec()), 64'b100);
    chk("release_addr", 64'(bus.wb_addr), 64'd7);

    // ---------------- asynchronous reset mid-operation ----------------
    do_reset();
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd1; bus.ld_data = 64'h11;
    bus.pc_valid = 1'b1; bus.pc_addr = 5'd2; bus.pc_data = 64'h22;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 64'h33;
    tick();
    tick();
    chk("arst_pre_en", 64'(bus.wb_en), 64'd1);
    chk("arst_pre_cnt", 64'(bus.conflict_cnt), 64'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_en", 64'(bus.wb_en), 64'd0);
    chk("arst_sel", 64'(sel_vec()), 64'd0);
    chk("arst_cnt", 64'(bus.conflict_cnt), 64'd0);
    chk("arst_ready", 64'(rdy_vec()), 64'd0);
    @(negedge clk);
    chk("arst_held_en", 64'(bus.wb_en), 64'd0);
    rstn = 1'b1;
    #1;
    chk("arst_first_ready", 64'(rdy_vec()), 64'b001);
    tick();
    chk("arst_first_sel", 64'(sel_vec()), 64'b001);
    chk("arst_first_cnt", 64'(bus.conflict_cnt), 64'd1);

    // ---------------- randomized against reference model ----------------
    do_reset();
    m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_sel = '0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!rv[i] && ($urandom_range(0, 2) == 0)) begin
          rv[i] = 1'b1;
          ra[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
          rd[i] = {$urandom, $urandom};
        end
      end
      bus.wb_hold = ($urandom_range(0, 4) == 0);
      drive_reqs();
      #1;
      g = -1;
      if (!bus.wb_hold) begin
        for (int k = 0; k < 3; k++) begin
          if (g < 0 && rv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        end
      end
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'd0;
      chk("rnd_ready", 64'(rdy_vec()), 64'(exp_rdy));
      nv = int'(rv[0]) + int'(rv[1]) + int'(rv[2]);
      if (!bus.wb_hold) begin
        if (nv >= 2 && m_cnt < 65535) m_cnt++;
        if (g >= 0) begin
          m_addr = ra[g];
          m_data = rd[g];
          m_en   = (ra[g] != 0);
          m_sel  = m_en ? 3'(1 << g) : 3'd0;
          m_ptr  = (g + 1) % 3;
          rv[g]  = 1'b0;
        end else begin
          m_en  = 1'b0;
          m_sel = 3'd0;
        end
      end
      tick();
      chk("rnd_en", 64'(bus.wb_en), 64'(m_en));
      chk("rnd_addr", 64'(bus.wb_addr), 64'(m_addr));
      chk("rnd_data", bus.wb_data, m_data);
      chk("rnd_sel", 64'(sel_vec()), 64'(m_sel));
      chk("rnd_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
    end

    // ---------------- counter saturation ----------------
    do_reset();
    bus.ld_valid = 1'b1; bus.pc_valid = 1'b1; bus.alu_valid = 1'b1;
    bus.ld_addr = 5'd1; bus.pc_addr = 5'd2; bus.alu_addr = 5'd3;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_pre", 64'(bus.conflict_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat%0d", i), 64'(bus.conflict_cnt), 64'hFFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 64, datapath width.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports ld_valid, pc_valid, alu_valid, input, 1 each, write requests from load unit, PC+4 path, and ALU.
REQ-006 SHALL have ports ld_addr, pc_addr, alu_addr, input, AW each, destination register per requester.
REQ-007 SHALL have ports ld_data, pc_data, alu_data, input, DW each, write data per requester.
REQ-008 SHALL have ports ld_ready, pc_ready, alu_ready, output, 1 each, combinational grant; a handshake occurs when valid and ready are both high.
REQ-009 SHALL have port wb_hold, input, 1, freezes arbitration and holds the output stage.
REQ-010 SHALL have ports wb_en, output, 1; wb_addr, output, AW; wb_data, output, DW; registered write-port drive to the register file.
REQ-011 SHALL have ports wb_load, wb_pc, wb_alu, output, 1 each, registered one-hot source select matching wb_data.
REQ-012 SHALL have port conflict_cnt, output, 16, saturating count of contention cycles.

Function
REQ-013 SHALL assert at most one ready per cycle, and only to a requester whose valid is high.
REQ-014 SHALL assert no ready while wb_hold is high.
REQ-015 SHALL grant by round-robin: search order starts at pointer ptr (0=load, 1=pc, 2=alu) and wraps 2->0.
REQ-016 SHALL set ptr to (granted index + 1) mod 3 on each handshake; ptr SHALL be unchanged on cycles without a handshake.
REQ-017 SHALL register the granted request into the output stage on the same edge as the handshake; wb_* SHALL be valid the following cycle (latency 1).
REQ-018 SHALL drive wb_en=1, wb_addr=addr, wb_data=data, and the matching one-hot select for a granted request with addr != 0.
REQ-019 SHALL complete a handshake for a request with addr == 0 but drive wb_en=0 and all selects 0 for it (x0 write discarded).
REQ-020 SHALL drive wb_en=0 and all selects 0 on any cycle following a non-hold cycle with no handshake; wb_addr/wb_data SHALL hold their previous values.
REQ-021 SHALL hold all wb_* outputs unchanged while wb_hold is high, including an active wb_en.
REQ-022 SHALL NOT merge or reorder same-address requests; each is written in grant order, with the later grant winning in the register file.
REQ-023 SHALL increment conflict_cnt by 1 on each cycle with two or more valids high and wb_hold low; it SHALL saturate at 0xFFFF.
REQ-024 SHALL require requesters to hold valid, addr, and data stable until the handshake; the arbiter does not check this.
REQ-025 SHALL ensure wb_load, wb_pc, and wb_alu are never simultaneously high.

Reset
REQ-026 SHALL, while rstn is low, asynchronously force ptr=0, wb_en=0, wb_addr=0, wb_data=0, all selects 0, and conflict_cnt=0.
REQ-027 SHALL drive all ready outputs 0 while rstn is low; a request in flight at reset assertion is dropped and never written.
REQ-028 SHALL resume arbitration on the first rising clk edge after rstn deasserts, with load at highest priority.

Verification
REQ-029 Single request: after reset, alu_valid=1, alu_addr=5, alu_data=0x1234 -> alu_ready=1 that cycle; next cycle wb_en=1, wb_addr=5, wb_data=0x1234, wb_alu=1.
REQ-030 Contention: all three valids held high from reset -> grants load, pc, alu, load in successive cycles; conflict_cnt=1,2,3 after the first three edges.
REQ-031 x0 write: pc_valid=1, pc_addr=0 -> pc_ready=1; next cycle wb_en=0 and wb_pc=0.
REQ-032 Hold: grant load to addr 3, then wb_hold=1 for 3 cycles with alu_valid=1 -> wb_en=1, wb_addr=3 held; alu_ready=0 throughout; conflict_cnt unchanged; alu granted on the first cycle after release.
REQ-033 Reset mid-operation: rstn pulsed low asynchronously (between edges) while wb_en=1 -> wb_en, selects, and conflict_cnt go 0 immediately; the first post-reset grant goes to load when all three valids are high.
REQ-034 Saturation: preload conflict_cnt to 0xFFFE via sustained contention, then 3 more contention cycles -> conflict_cnt stays at 0xFFFF.
